// File: rtl/rom_bus_pkg.sv
// rtl/rom_bus_pkg.sv - shared types and constants for the ROM read bridge
// Contents:
//   state_t          bridge FSM state encoding
//   ROM_AW, DW       ROM address width and data width
//   ROM_BASE_DEFAULT default base of the 32 KiB ROM window
//   in_rom_window()  window decode helper
package rom_bus_pkg;

    localparam int ROM_AW = 15;
    localparam int DW     = 8;
    localparam int CPU_AW = 16;

    localparam logic [CPU_AW-1:0] ROM_BASE_DEFAULT = 16'h8000;

    // The window is 32 KiB aligned, so only the top address bit selects it.
    localparam logic [CPU_AW-1:0] ROM_WIN_MASK = 16'h8000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_ACK     = 2'd3
    } state_t;

    function automatic logic in_rom_window(input logic [CPU_AW-1:0] addr,
                                           input logic [CPU_AW-1:0] base);
        return (((addr ^ base) & ROM_WIN_MASK) == '0);
    endfunction

endpackage

// File: rtl/rom_read_bridge_if.sv
// rtl/rom_read_bridge_if.sv - CPU-side request/response bus of the ROM read bridge
// Signals:
//   req_valid/req_ready  request handshake, accepted when both are high
//   req_addr, req_rw     16-bit byte address and direction (1 = read)
//   rsp_ack              one-cycle completion pulse
//   rsp_data, rsp_err    read data and error flag, qualified by rsp_ack
// Modports:
//   master  the CPU issuing requests
//   slave   the bridge answering them
interface rom_read_bridge_if;
    import rom_bus_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [CPU_AW-1:0] req_addr;
    logic              req_rw;
    logic              rsp_ack;
    logic [DW-1:0]     rsp_data;
    logic              rsp_err;

    modport master (
        output req_valid,
        output req_addr,
        output req_rw,
        input  req_ready,
        input  rsp_ack,
        input  rsp_data,
        input  rsp_err
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  req_rw,
        output req_ready,
        output rsp_ack,
        output rsp_data,
        output rsp_err
    );

endinterface

// File: rtl/rom_last_read_cache.sv
// rtl/rom_last_read_cache.sv - one-entry cache of the last byte fetched from ROM
// Ports:
//   clk, rst      clock and synchronous active-high reset (invalidates the entry)
//   lookup_addr   ROM offset being requested
//   hit           entry valid and matches lookup_addr (always 0 when CACHE_EN=0)
//   hit_data      cached byte
//   fill_en       load the entry this cycle
//   fill_addr     ROM offset being loaded
//   fill_data     byte being loaded
module rom_last_read_cache
    import rom_bus_pkg::*;
#(
    parameter bit CACHE_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ROM_AW-1:0] lookup_addr,
    output logic              hit,
    output logic [DW-1:0]     hit_data,
    input  logic              fill_en,
    input  logic [ROM_AW-1:0] fill_addr,
    input  logic [DW-1:0]     fill_data
);

    logic              valid_q, valid_d;
    logic [ROM_AW-1:0] addr_q,  addr_d;
    logic [DW-1:0]     data_q,  data_d;

    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        if (fill_en) begin
            // With the cache disabled the entry is still written but never
            // marked valid, so it can never produce a hit.
            valid_d = CACHE_EN;
            addr_d  = fill_addr;
            data_d  = fill_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign hit      = CACHE_EN && valid_q && (lookup_addr == addr_q);
    assign hit_data = data_q;

endmodule

// File: rtl/rom_read_bridge.sv
// rtl/rom_read_bridge.sv - CPU read front end for the 32 KiB firmware ROM
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   bus        CPU request/response bus (slave side)
//   rom_addr   15-bit ROM address
//   rom_oen    active-low ROM output enable
//   rom_data   ROM registered read data (high-Z while disabled)
// Parameters:
//   ROM_BASE   base of the ROM window (32 KiB aligned)
//   CACHE_EN   1 = serve repeated reads of the last byte from the cache
module rom_read_bridge
    import rom_bus_pkg::*;
#(
    parameter logic [CPU_AW-1:0] ROM_BASE = ROM_BASE_DEFAULT,
    parameter bit                CACHE_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    rom_read_bridge_if.slave  bus,
    output logic [ROM_AW-1:0] rom_addr,
    output logic              rom_oen,
    input  logic [DW-1:0]     rom_data
);

    state_t            state_q,     state_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_ack_q,   rsp_ack_d;
    logic              rsp_err_q,   rsp_err_d;
    logic [DW-1:0]     rsp_data_q,  rsp_data_d;
    logic [ROM_AW-1:0] rom_addr_q,  rom_addr_d;
    logic              rom_oen_q,   rom_oen_d;

    logic              in_win;
    logic              cache_hit;
    logic [DW-1:0]     cache_data;
    logic              cache_fill;

    assign in_win = in_rom_window(bus.req_addr, ROM_BASE);

    rom_last_read_cache #(
        .CACHE_EN (CACHE_EN)
    ) u_cache (
        .clk         (clk),
        .rst         (rst),
        .lookup_addr (bus.req_addr[ROM_AW-1:0]),
        .hit         (cache_hit),
        .hit_data    (cache_data),
        .fill_en     (cache_fill),
        .fill_addr   (rom_addr_q),
        .fill_data   (rom_data)
    );

    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        rsp_ack_d   = 1'b0;
        rsp_err_d   = rsp_err_q;
        rsp_data_d  = rsp_data_q;
        rom_addr_d  = rom_addr_q;
        rom_oen_d   = rom_oen_q;
        cache_fill  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // req_ready_q is high throughout IDLE, so req_valid alone
                // is the accept condition here.
                if (bus.req_valid) begin
                    req_ready_d = 1'b0;
                    if (bus.req_rw && in_win && cache_hit) begin
                        rsp_data_d = cache_data;
                        rsp_err_d  = 1'b0;
                        rsp_ack_d  = 1'b1;
                        state_d    = ST_ACK;
                    end else if (bus.req_rw && in_win) begin
                        rom_addr_d = bus.req_addr[ROM_AW-1:0];
                        rom_oen_d  = 1'b0;
                        rsp_err_d  = 1'b0;
                        state_d    = ST_ISSUE;
                    end else begin
                        // Writes and out-of-window reads leave rsp_data,
                        // the ROM pins and the cache untouched.
                        rsp_err_d = 1'b1;
                        rsp_ack_d = 1'b1;
                        state_d   = ST_ACK;
                    end
                end
            end

            ST_ISSUE: begin
                // The ROM registers its output at the end of this cycle.
                state_d = ST_CAPTURE;
            end

            ST_CAPTURE: begin
                // rom_oen is still low this cycle, so rom_data is driven.
                rsp_data_d = rom_data;
                cache_fill = 1'b1;
                rom_oen_d  = 1'b1;
                rsp_ack_d  = 1'b1;
                state_d    = ST_ACK;
            end

            ST_ACK: begin
                req_ready_d = 1'b1;
                state_d     = ST_IDLE;
            end

            default: begin
                req_ready_d = 1'b1;
                rom_oen_d   = 1'b1;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
            rsp_ack_q   <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
            rom_addr_q  <= '0;
            rom_oen_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_ack_q   <= rsp_ack_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
            rom_addr_q  <= rom_addr_d;
            rom_oen_q   <= rom_oen_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_ack   = rsp_ack_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_data  = rsp_data_q;
    assign rom_addr      = rom_addr_q;
    assign rom_oen       = rom_oen_q;

endmodule

// File: tb/tb_rom_read_bridge.sv
// tb/tb_rom_read_bridge.sv - self-checking bench for rom_read_bridge (cached and uncached)
module tb_rom_read_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_valid = 1'b0;
    logic        cpu_rw = 1'b1;
    logic [15:0] cpu_addr = 16'h0000;
    int          sel = 0;
    bit          chk_en = 1'b0;

    int vectors = 0;
    int errors  = 0;
    int oen_lo  = 0;

    always #5 clk = ~clk;

    rom_read_bridge_if bus0 ();
    rom_read_bridge_if bus1 ();

    assign bus0.req_valid = cpu_valid && (sel == 0);
    assign bus0.req_addr  = cpu_addr;
    assign bus0.req_rw    = cpu_rw;
    assign bus1.req_valid = cpu_valid && (sel == 1);
    assign bus1.req_addr  = cpu_addr;
    assign bus1.req_rw    = cpu_rw;

    logic [14:0] rom_addr0, rom_addr1;
    logic        rom_oen0, rom_oen1;
    logic [7:0]  rom_q0 = 8'h00, rom_q1 = 8'h00;
    wire  [7:0]  rom_data0, rom_data1;
    logic [7:0]  rom_mem [0:32767];

    initial begin
        for (int i = 0; i < 32768; i++) begin
            logic [14:0] ia;
            ia = 15'(i);
            rom_mem[i] = ia[7:0] ^ 8'h5A;
        end
    end

    always @(posedge clk) if (!rom_oen0) rom_q0 <= rom_mem[rom_addr0];
    always @(posedge clk) if (!rom_oen1) rom_q1 <= rom_mem[rom_addr1];
    assign rom_data0 = rom_oen0 ? 8'hzz : rom_q0;
    assign rom_data1 = rom_oen1 ? 8'hzz : rom_q1;

    rom_read_bridge #(.ROM_BASE(16'h8000), .CACHE_EN(1'b1)) dut0 (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus0),
        .rom_addr (rom_addr0),
        .rom_oen  (rom_oen0),
        .rom_data (rom_data0)
    );

    rom_read_bridge #(.ROM_BASE(16'h8000), .CACHE_EN(1'b0)) dut1 (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus1),
        .rom_addr (rom_addr1),
        .rom_oen  (rom_oen1),
        .rom_data (rom_data1)
    );

    logic        d_ready [2];
    logic        d_ack   [2];
    logic        d_err   [2];
    logic [7:0]  d_data  [2];
    logic        d_oen   [2];
    logic [14:0] d_raddr [2];

    assign d_ready[0] = bus0.req_ready;
    assign d_ack[0]   = bus0.rsp_ack;
    assign d_err[0]   = bus0.rsp_err;
    assign d_data[0]  = bus0.rsp_data;
    assign d_oen[0]   = rom_oen0;
    assign d_raddr[0] = rom_addr0;
    assign d_ready[1] = bus1.req_ready;
    assign d_ack[1]   = bus1.rsp_ack;
    assign d_err[1]   = bus1.rsp_err;
    assign d_data[1]  = bus1.rsp_data;
    assign d_oen[1]   = rom_oen1;
    assign d_raddr[1] = rom_addr1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] rom_val(input logic [14:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    // Transaction-level model: m_age counts cycles since the accept edge
    // (-1 when idle); the response appears when m_age reaches m_lat.
    int          m_age [2] = '{-1, -1};
    int          m_lat [2] = '{1, 1};
    logic        m_miss[2] = '{1'b0, 1'b0};
    logic        m_err [2] = '{1'b0, 1'b0};
    logic        m_cv  [2] = '{1'b0, 1'b0};
    logic [14:0] m_ca  [2];
    logic [7:0]  m_cd  [2];
    logic [7:0]  m_data[2] = '{8'h00, 8'h00};
    logic [7:0]  m_pdata[2];
    logic [15:0] m_addr[2];
    bit          m_acc [2] = '{1'b0, 1'b0};
    logic        mv;

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            mv = cpu_valid && (sel == k);
            m_acc[k] = 1'b0;
            if (rst) begin
                m_age[k]  = -1;
                m_cv[k]   = 1'b0;
                m_data[k] = 8'h00;
                m_err[k]  = 1'b0;
                m_miss[k] = 1'b0;
            end else if (m_age[k] >= 1) begin
                if (m_age[k] == m_lat[k]) begin
                    m_age[k] = -1;
                end else begin
                    m_age[k]++;
                    if (m_age[k] == m_lat[k]) begin
                        m_data[k] = m_pdata[k];
                        m_cv[k]   = (k == 0);
                        m_ca[k]   = m_addr[k][14:0];
                        m_cd[k]   = m_pdata[k];
                    end
                end
            end else if (mv) begin
                m_acc[k]   = 1'b1;
                m_age[k]   = 1;
                m_addr[k]  = cpu_addr;
                m_miss[k]  = 1'b0;
                m_pdata[k] = m_data[k];
                if (!cpu_rw || !cpu_addr[15]) begin
                    m_lat[k] = 1;
                    m_err[k] = 1'b1;
                end else if (k == 0 && m_cv[k] && cpu_addr[14:0] == m_ca[k]) begin
                    m_lat[k]   = 1;
                    m_err[k]   = 1'b0;
                    m_pdata[k] = m_cd[k];
                end else begin
                    m_lat[k]   = 3;
                    m_err[k]   = 1'b0;
                    m_miss[k]  = 1'b1;
                    m_pdata[k] = rom_val(cpu_addr[14:0]);
                end
                if (m_lat[k] == 1) m_data[k] = m_pdata[k];
            end
        end
    end

    logic exp_ack, exp_oen_lo;
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                exp_ack    = (m_age[k] >= 1) && (m_age[k] == m_lat[k]);
                exp_oen_lo = m_miss[k] && (m_age[k] == 1 || m_age[k] == 2);
                chk($sformatf("d%0d_ready", k), 32'(d_ready[k]), 32'(m_age[k] < 0));
                chk($sformatf("d%0d_ack", k), 32'(d_ack[k]), 32'(exp_ack));
                chk($sformatf("d%0d_data", k), 32'(d_data[k]), 32'(m_data[k]));
                chk($sformatf("d%0d_oen", k), 32'(d_oen[k]), 32'(!exp_oen_lo));
                if (exp_ack)
                    chk($sformatf("d%0d_err", k), 32'(d_err[k]), 32'(m_err[k]));
                if (exp_oen_lo)
                    chk($sformatf("d%0d_rom_addr", k), 32'(d_raddr[k]), 32'(m_addr[k][14:0]));
            end
        end
    end

    always @(negedge clk) if (!d_oen[sel]) oen_lo++;

    task automatic do_req(input int k, input logic [15:0] a, input logic rw,
                          output int lat, output logic [7:0] d, output logic e);
        bit acc;
        acc = 1'b0;
        lat = 0;
        d   = 8'h00;
        e   = 1'b0;
        @(negedge clk);
        sel = k; cpu_addr = a; cpu_rw = rw; cpu_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (m_acc[k]) begin acc = 1'b1; break; end
        end
        chk("accept", 32'(acc), 32'd1);
        if (acc) begin
            for (int i = 1; i <= 10; i++) begin
                @(negedge clk);
                if (i == 1) cpu_valid = 1'b0;
                if (d_ack[k]) begin
                    lat = i; d = d_data[k]; e = d_err[k];
                    break;
                end
            end
        end
        cpu_valid = 1'b0;
    endtask

    int         lat, n, acks, first_ack;
    logic [7:0] d, d1, d2;
    logic       e;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        chk("rst_ready", 32'(d_ready[0]), 32'd1);
        chk("rst_ack", 32'(d_ack[0]), 32'd0);
        chk("rst_err", 32'(d_err[0]), 32'd0);
        chk("rst_data", 32'(d_data[0]), 32'h00);
        chk("rst_rom_addr", 32'(d_raddr[0]), 32'h0000);
        chk("rst_oen", 32'(d_oen[0]), 32'd1);

        // Miss
        oen_lo = 0;
        do_req(0, 16'hFFFC, 1'b1, lat, d, e);
        chk("miss_lat", lat, 3);
        chk("miss_data", 32'(d), 32'hA6);
        chk("miss_err", 32'(e), 32'd0);
        chk("miss_oen_cycles", oen_lo, 2);
        chk("miss_rom_addr", 32'(d_raddr[0]), 32'h7FFC);

        // Hit
        oen_lo = 0;
        do_req(0, 16'hFFFC, 1'b1, lat, d, e);
        chk("hit_lat", lat, 1);
        chk("hit_data", 32'(d), 32'hA6);
        chk("hit_oen_cycles", oen_lo, 0);

        // Errors
        oen_lo = 0;
        do_req(0, 16'h7FFF, 1'b1, lat, d, e);
        chk("oow_lat", lat, 1);
        chk("oow_err", 32'(e), 32'd1);
        chk("oow_data", 32'(d), 32'hA6);
        do_req(0, 16'h9000, 1'b0, lat, d, e);
        chk("wr_lat", lat, 1);
        chk("wr_err", 32'(e), 32'd1);
        chk("wr_data", 32'(d), 32'hA6);
        chk("err_oen_cycles", oen_lo, 0);
        do_req(0, 16'hFFFC, 1'b1, lat, d, e);
        chk("hit_after_err_lat", lat, 1);

        // Top window edge
        do_req(0, 16'hFFFF, 1'b1, lat, d, e);
        chk("top_lat", lat, 3);
        chk("top_data", 32'(d), 32'hA5);
        chk("top_rom_addr", 32'(d_raddr[0]), 32'h7FFF);

        // Back-to-back with req_valid held high
        @(negedge clk);
        sel = 0; cpu_addr = 16'h8000; cpu_rw = 1'b1; cpu_valid = 1'b1;
        acks = 0; first_ack = 0; d1 = 8'h00; d2 = 8'h00;
        for (n = 1; n <= 20 && acks < 2; n++) begin
            @(negedge clk);
            if (d_ack[0]) begin
                acks++;
                if (acks == 1) begin
                    d1 = d_data[0]; first_ack = n; cpu_addr = 16'h8001;
                end else begin
                    d2 = d_data[0]; cpu_valid = 1'b0;
                    chk("b2b_gap", n - first_ack, 4);
                end
            end
        end
        cpu_valid = 1'b0;
        chk("b2b_acks", acks, 2);
        chk("b2b_data0", 32'(d1), 32'h5A);
        chk("b2b_data1", 32'(d2), 32'h5B);

        // req_valid during ISSUE/CAPTURE/ACK is ignored
        @(negedge clk);
        sel = 0; cpu_addr = 16'h8030; cpu_rw = 1'b1; cpu_valid = 1'b1;
        acks = 0; d = 8'h00;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i <= 3) cpu_addr = 16'h1234;
            else cpu_valid = 1'b0;
            if (d_ack[0]) begin acks++; d = d_data[0]; end
        end
        chk("hs_acks", acks, 1);
        chk("hs_data", 32'(d), 32'h6A);

        // Reset in CAPTURE
        @(negedge clk);
        sel = 0; cpu_addr = 16'h8020; cpu_rw = 1'b1; cpu_valid = 1'b1;
        @(negedge clk);
        cpu_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_oen", 32'(d_oen[0]), 32'd1);
        acks = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (d_ack[0]) acks++;
        end
        chk("rst_mid_no_ack", acks, 0);
        do_req(0, 16'h8030, 1'b1, lat, d, e);
        chk("after_rst_lat", lat, 3);
        chk("after_rst_data", 32'(d), 32'h6A);

        // Reset and req_valid together: reset wins
        @(negedge clk);
        sel = 0; cpu_addr = 16'hFFFC; cpu_rw = 1'b1; cpu_valid = 1'b1; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; cpu_valid = 1'b0;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (d_ack[0]) acks++;
        end
        chk("rst_req_no_ack", acks, 0);

        // Uncached instance
        oen_lo = 0;
        do_req(1, 16'hFFFC, 1'b1, lat, d, e);
        chk("nc_first_lat", lat, 3);
        chk("nc_first_data", 32'(d), 32'hA6);
        chk("nc_first_oen_cycles", oen_lo, 2);
        oen_lo = 0;
        do_req(1, 16'hFFFC, 1'b1, lat, d, e);
        chk("nc_repeat_lat", lat, 3);
        chk("nc_repeat_data", 32'(d), 32'hA6);
        chk("nc_repeat_oen_cycles", oen_lo, 2);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/rom_read_bridge.md
Name: rom_read_bridge

Overview:
- Bus-side front end for the 32 KiB drive-firmware ROM (15-bit address, registered 8-bit read data, active-low output enable, data high-Z when disabled).
- Accepts single-beat CPU read requests on a 16-bit address bus and decodes the ROM window.
- Sequences the ROM's output-enable and one-cycle read latency, then returns data with a one-cycle ack.
- Includes a one-entry last-read cache so repeated fetches of the same byte bypass the ROM.

Parameters:
- ROM_BASE, 16'h8000, base of ROM window; window = ROM_BASE .. ROM_BASE+16'h7FFF; must be 32 KiB aligned.
- CACHE_EN, 1, 1 = enable last-read cache; 0 = every read goes to ROM.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request strobe; accepted on a cycle where req_valid & req_ready.
- req_ready  out  1  high only in IDLE.
- req_addr  in  16  CPU byte address, sampled on accept.
- req_rw  in  1  1 = read, 0 = write, sampled on accept.
- rsp_ack  out  1  one-cycle pulse; completes the accepted request.
- rsp_data  out  8  read data; valid when rsp_ack=1, holds its value otherwise.
- rsp_err  out  1  qualified by rsp_ack; 1 = out-of-window access or write to ROM window.
- rom_addr  out  15  address to ROM.
- rom_oen  out  1  active-low ROM output enable.
- rom_data  in  8  ROM registered output; high-Z while ROM is disabled; sampled only in CAPTURE.

Behaviour:
- Reset values:
  - state=IDLE, req_ready=1, rsp_ack=0, rsp_err=0.
  - rsp_data=8'h00, rom_addr=15'h0000, rom_oen=1.
  - cache_valid=0.
- States: IDLE, ISSUE, CAPTURE, ACK.
- Hit definition: in_win = (req_addr[15] == ROM_BASE[15]). Hit = CACHE_EN & cache_valid & (req_addr[14:0] == cache_addr).
- IDLE, on accept, exactly one of:
  - read & in_win & hit: go to ACK; rsp_data <= cache_data; err=0.
  - read & in_win & miss: rom_addr <= req_addr[14:0]; rom_oen <= 0; go to ISSUE.
  - write, or !in_win: go to ACK with err=1; rsp_data unchanged; ROM untouched.
- ISSUE (1 cycle): rom_oen=0 and rom_addr held. The ROM registers the data at the closing edge. Go to CAPTURE.
- CAPTURE (1 cycle):
  - rom_oen held 0 so rom_data stays driven.
  - At the closing edge: rsp_data <= rom_data; cache_addr <= rom_addr; cache_data <= rom_data; cache_valid <= CACHE_EN.
  - Set rom_oen <= 1; go to ACK.
- ACK (1 cycle): rsp_ack=1, rsp_err valid, req_ready=0. Next state IDLE.
- Back-to-back: a new request can be accepted in the IDLE cycle immediately after ACK.
- Latency, measured in cycles from the accept edge to the rsp_ack-high cycle:
  - ROM miss: 3.
  - Cache hit: 1.
  - Error: 1.
- rom_oen is low for exactly 2 cycles per miss, never outside ISSUE/CAPTURE.
- req_valid outside IDLE is ignored; the requester holds it until req_ready.
- rst in any state:
  - Next cycle: IDLE with rom_oen=1, no ack, and cache invalidated.
  - A request in flight is dropped, with no ack.
- rst and req_valid in the same cycle: reset wins; the request is not accepted.
- Window edges:
  - 16'h8000 maps to rom_addr 15'h0000.
  - 16'hFFFF maps to rom_addr 15'h7FFF.
  - 16'h7FFF gives an error.
- Writes never disturb the cache.

Decomposition:
- Shared package rom_bus_pkg holds:
  - state encoding constants (IDLE=2'd0, ISSUE=2'd1, CAPTURE=2'd2, ACK=2'd3);
  - ROM_AW=15 and DW=8;
  - the default ROM_BASE.
- One natural sub-module: rom_last_read_cache. It holds the valid/addr/data registers plus the hit compare. CACHE_EN=0 ties hit to 0.
- The FSM stays in rom_read_bridge.

Test Plan:
- Use a ROM model with registered output, high-Z when disabled, preloaded with mem[i] = i[7:0] ^ 8'h5A.
- Miss read: read 16'hFFFC after reset.
  - rom_oen low for cycles 1-2 and rom_addr=15'h7FFC.
  - rsp_ack in cycle 3 with rsp_data=8'hA6, rsp_err=0.
- Cache hit: repeat read 16'hFFFC.
  - rsp_ack one cycle after accept, data 8'hA6.
  - rom_oen stays 1 throughout.
  - With CACHE_EN=0 the same stimulus takes 3 cycles and toggles rom_oen.
- Errors:
  - Read 16'h7FFF gives ack after 1 cycle, rsp_err=1, rsp_data unchanged, rom_oen=1.
  - Write 16'h9000 gives the same response.
  - A following read of the cached address still hits.
- Back-to-back: reads 16'h8000 then 16'h8001 with req_valid held high.
  - Second accept occurs in the IDLE cycle after the first ack.
  - Data 8'h5A then 8'h5B.
- Reset mid-operation: assert rst in CAPTURE.
  - No rsp_ack; rom_oen=1 the next cycle.
  - Re-reading the same address takes a 3-cycle miss, proving the cache was cleared.
- Handshake: req_valid pulsed during ISSUE/CAPTURE/ACK is ignored; exactly one ack per accepted request.
